psk_frame_sched: RTL and testbench

- Frame scheduler in front of the Tx byte interface in the clk_1M024 domain.
- Shares the single Tx byte stream between two requesters: port 0 for control frames and port 1 for payload frames.
- For each frame it emits one header byte, forwards the granted requester's bytes, and enforces a maximum frame length and an inter-frame gap.
- Drives the per-frame 4-bit one-hot MODE_CTRL so BPSK and QPSK frames can be mixed on the link.

---
 rtl/psk_frame_sched_pkg.sv | 33 +++
 rtl/psk_rr_arb2.sv | 37 +++
 rtl/psk_frame_sched.sv | 193 +++++++++++++++++++
 tb/tb_psk_frame_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_frame_sched_pkg.sv
// Shared definitions for the PSK frame scheduler.
// Holds the one-hot mode constants (also used by the Tx/Rx benches), the
// default header tag, the scheduler state encoding and the helper that
// maps the requested mode plus the granted port to the per-frame mode.
package psk_frame_sched_pkg;

    localparam logic [3:0] MODE_BPSK       = 4'b0001;
    localparam logic [3:0] MODE_QPSK       = 4'b0010;
    localparam logic [3:0] MODE_MIX        = 4'b0100;
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_GAP
    } sched_state_t;

    // MIX splits the ports: control frames go out BPSK, payload frames QPSK.
    // Any value that is not a legal one-hot request falls back to BPSK.
    function automatic logic [3:0] frame_mode(input logic [3:0] cfg, input logic port);
        logic [3:0] m;
        m = MODE_BPSK;
        if (cfg == MODE_MIX) begin
            m = port ? MODE_QPSK : MODE_BPSK;
        end else if (cfg == MODE_QPSK) begin
            m = MODE_QPSK;
        end
        return m;
    endfunction

endpackage

// File: rtl/psk_rr_arb2.sv
// Two-way alternating-priority arbiter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : request vector, bit N from requester N
//   take       : commit the current winner as the last grant
//   winner     : index of the requester that would be granted now
// The last-grant register resets to 1 so that port 0 wins the first tie.
module psk_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       winner
);

    logic last_grant;

    // On a tie, favour the port that was not granted last time.
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/psk_frame_sched.sv
// Frame scheduler in front of the Tx byte interface (clk_1M024 domain).
// Shares the Tx byte stream between a control requester (s0) and a payload
// requester (s1). Each frame gets a header byte {HDR_TAG, mode}, then the
// granted requester's bytes, truncated at MAX_LEN, followed by an IFG_CYCLES
// idle gap.
// Ports:
//   clk_1M024, rst_n_1M024       : clock, async active-low reset
//   mode_cfg                     : requested one-hot mode, sampled at grant
//   s0_* / s1_*                  : control / payload requester streams
//   m_tdata/tvalid/tlast/tuser   : registered Tx byte stream (tuser = header)
//   m_tready                     : Tx accepts the current beat
//   MODE_CTRL                    : one-hot mode of the frame in flight
//   busy                         : scheduler is not idle
//   ovf_cnt                      : saturating count of truncated frames
module psk_frame_sched
    import psk_frame_sched_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned IFG_CYCLES = 16,
    parameter logic [3:0]  HDR_TAG    = HDR_TAG_DEFAULT
) (
    input  logic       clk_1M024,
    input  logic       rst_n_1M024,
    input  logic [3:0] mode_cfg,
    input  logic [7:0] s0_tdata,
    input  logic       s0_tvalid,
    input  logic       s0_tlast,
    output logic       s0_tready,
    input  logic [7:0] s1_tdata,
    input  logic       s1_tvalid,
    input  logic       s1_tlast,
    output logic       s1_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic       m_tuser,
    input  logic       m_tready,
    output logic [3:0] MODE_CTRL,
    output logic       busy,
    output logic [7:0] ovf_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [7:0] IFG_B     = 8'(IFG_CYCLES);

    sched_state_t state, state_nx;
    logic         grant, grant_nx;
    logic [3:0]   fmode, fmode_nx;
    logic [7:0]   byte_cnt, byte_cnt_nx;
    logic [7:0]   gap_cnt, gap_cnt_nx;
    logic [7:0]   ovf_nx;
    logic [3:0]   mode_nx;
    logic [7:0]   td_nx;
    logic         tv_nx, tl_nx, tu_nx;

    logic         arb_winner, arb_take;
    logic         load_ok, src_valid, src_last, src_ready, accept;
    logic [7:0]   src_data;

    psk_rr_arb2 u_arb (
        .clk    (clk_1M024),
        .rst_n  (rst_n_1M024),
        .req    ({s1_tvalid, s0_tvalid}),
        .take   (arb_take),
        .winner (arb_winner)
    );

    assign load_ok   = !m_tvalid || m_tready;
    assign src_valid = grant ? s1_tvalid : s0_tvalid;
    assign src_last  = grant ? s1_tlast  : s0_tlast;
    assign src_data  = grant ? s1_tdata  : s0_tdata;
    assign busy      = (state != ST_IDLE);

    // Forwarding needs room in the output register; draining just discards.
    always_comb begin
        src_ready = 1'b0;
        if (state == ST_PAYLOAD) begin
            src_ready = load_ok;
        end else if (state == ST_DRAIN) begin
            src_ready = 1'b1;
        end
    end

    assign s0_tready = src_ready && !grant;
    assign s1_tready = src_ready &&  grant;
    assign accept    = src_valid && src_ready;

    // Next-state and output-register logic. The output register only clears
    // m_tvalid when its beat is taken and nothing new is loaded.
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        fmode_nx    = fmode;
        byte_cnt_nx = byte_cnt;
        gap_cnt_nx  = gap_cnt;
        ovf_nx      = ovf_cnt;
        mode_nx     = MODE_CTRL;
        td_nx       = m_tdata;
        tv_nx       = m_tvalid && !m_tready;
        tl_nx       = m_tlast;
        tu_nx       = m_tuser;
        arb_take    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    arb_take = 1'b1;
                    grant_nx = arb_winner;
                    fmode_nx = frame_mode(mode_cfg, arb_winner);
                    state_nx = ST_HDR;
                end
            end
            ST_HDR: begin
                if (load_ok) begin
                    td_nx       = {HDR_TAG, fmode};
                    tv_nx       = 1'b1;
                    tu_nx       = 1'b1;
                    tl_nx       = 1'b0;
                    mode_nx     = fmode;
                    byte_cnt_nx = 8'd0;
                    state_nx    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    td_nx       = src_data;
                    tv_nx       = 1'b1;
                    tu_nx       = 1'b0;
                    tl_nx       = 1'b0;
                    byte_cnt_nx = byte_cnt + 8'd1;
                    // A source tlast on byte MAX_LEN ends the frame normally.
                    if (src_last) begin
                        tl_nx      = 1'b1;
                        gap_cnt_nx = 8'd0;
                        state_nx   = ST_GAP;
                    end else if (byte_cnt + 8'd1 == MAX_LEN_B) begin
                        tl_nx    = 1'b1;
                        state_nx = ST_DRAIN;
                        if (ovf_cnt != 8'hFF) begin
                            ovf_nx = ovf_cnt + 8'd1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && src_last) begin
                    gap_cnt_nx = 8'd0;
                    state_nx   = ST_GAP;
                end
            end
            ST_GAP: begin
                // The gap only starts counting once the final beat has left.
                if (!(m_tvalid && !m_tready)) begin
                    if (gap_cnt == IFG_B) begin
                        state_nx = ST_IDLE;
                    end else begin
                        gap_cnt_nx = gap_cnt + 8'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            state     <= ST_IDLE;
            grant     <= 1'b0;
            fmode     <= MODE_BPSK;
            byte_cnt  <= 8'd0;
            gap_cnt   <= 8'd0;
            ovf_cnt   <= 8'd0;
            MODE_CTRL <= MODE_BPSK;
            m_tdata   <= 8'd0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            m_tuser   <= 1'b0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            fmode     <= fmode_nx;
            byte_cnt  <= byte_cnt_nx;
            gap_cnt   <= gap_cnt_nx;
            ovf_cnt   <= ovf_nx;
            MODE_CTRL <= mode_nx;
            m_tdata   <= td_nx;
            m_tvalid  <= tv_nx;
            m_tlast   <= tl_nx;
            m_tuser   <= tu_nx;
        end
    end

endmodule

// File: tb/tb_psk_frame_sched.sv
// Scoreboard bench for psk_frame_sched.
// Two instances: dut_a with default parameters (MAX_LEN=64, IFG=16) and
// dut_b with MAX_LEN=4, IFG=2 for the truncation cases. The 'sel' variable
// routes the requester valids to one instance and muxes its outputs back.
module tb_psk_frame_sched;
    import psk_frame_sched_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
        logic [3:0] mode;
    } beat_t;

    logic       clk_1M024 = 1'b0;
    logic       rst_n_1M024;
    logic [3:0] mode_cfg;
    logic [7:0] s0_tdata, s1_tdata;
    logic       s0_tvalid, s0_tlast, s1_tvalid, s1_tlast;
    logic       m_tready;
    logic       sel;
    logic       rand_ready;

    logic [7:0] a_tdata, b_tdata, a_ovf, b_ovf;
    logic       a_tvalid, a_tlast, a_tuser, a_busy, a_s0_rdy, a_s1_rdy;
    logic       b_tvalid, b_tlast, b_tuser, b_busy, b_s0_rdy, b_s1_rdy;
    logic [3:0] a_mode, b_mode;

    logic [7:0] mx_tdata, mx_ovf;
    logic       mx_tvalid, mx_tlast, mx_tuser, mx_busy, mx_s0_rdy, mx_s1_rdy;
    logic [3:0] mx_mode;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_en = 1'b0;

    always #5 clk_1M024 = ~clk_1M024;

    psk_frame_sched dut_a (
        .clk_1M024   (clk_1M024),
        .rst_n_1M024 (rst_n_1M024),
        .mode_cfg    (mode_cfg),
        .s0_tdata    (s0_tdata),
        .s0_tvalid   (s0_tvalid && !sel),
        .s0_tlast    (s0_tlast),
        .s0_tready   (a_s0_rdy),
        .s1_tdata    (s1_tdata),
        .s1_tvalid   (s1_tvalid && !sel),
        .s1_tlast    (s1_tlast),
        .s1_tready   (a_s1_rdy),
        .m_tdata     (a_tdata),
        .m_tvalid    (a_tvalid),
        .m_tlast     (a_tlast),
        .m_tuser     (a_tuser),
        .m_tready    (m_tready),
        .MODE_CTRL   (a_mode),
        .busy        (a_busy),
        .ovf_cnt     (a_ovf)
    );

    psk_frame_sched #(.MAX_LEN(4), .IFG_CYCLES(2)) dut_b (
        .clk_1M024   (clk_1M024),
        .rst_n_1M024 (rst_n_1M024),
        .mode_cfg    (mode_cfg),
        .s0_tdata    (s0_tdata),
        .s0_tvalid   (s0_tvalid && sel),
        .s0_tlast    (s0_tlast),
        .s0_tready   (b_s0_rdy),
        .s1_tdata    (s1_tdata),
        .s1_tvalid   (s1_tvalid && sel),
        .s1_tlast    (s1_tlast),
        .s1_tready   (b_s1_rdy),
        .m_tdata     (b_tdata),
        .m_tvalid    (b_tvalid),
        .m_tlast     (b_tlast),
        .m_tuser     (b_tuser),
        .m_tready    (m_tready),
        .MODE_CTRL   (b_mode),
        .busy        (b_busy),
        .ovf_cnt     (b_ovf)
    );

    assign mx_tdata  = sel ? b_tdata  : a_tdata;
    assign mx_tvalid = sel ? b_tvalid : a_tvalid;
    assign mx_tlast  = sel ? b_tlast  : a_tlast;
    assign mx_tuser  = sel ? b_tuser  : a_tuser;
    assign mx_mode   = sel ? b_mode   : a_mode;
    assign mx_busy   = sel ? b_busy   : a_busy;
    assign mx_ovf    = sel ? b_ovf    : a_ovf;
    assign mx_s0_rdy = sel ? b_s0_rdy : a_s0_rdy;
    assign mx_s1_rdy = sel ? b_s1_rdy : a_s1_rdy;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushBeat(input logic [7:0] d, input logic u, input logic l, input logic [3:0] m);
        beat_t b;
        b.data = d;
        b.user = u;
        b.last = l;
        b.mode = m;
        sb.push_back(b);
    endtask

    // Header byte, then n_out bytes base, base+step, ... with tlast on the last.
    task automatic expectFrame(input logic [7:0] hdr, input logic [3:0] m,
                               input logic [7:0] base, input logic [7:0] step, input int n_out);
        pushBeat(hdr, 1'b1, 1'b0, m);
        for (int i = 0; i < n_out; i++) begin
            pushBeat(8'(base + 8'(i) * step), 1'b0, (i == n_out - 1), m);
        end
    endtask

    // Sends n bytes on one requester port, honouring its tready.
    task automatic applyStimulus(input bit port, input logic [7:0] base,
                                 input logic [7:0] step, input int n);
        int  i = 0;
        int  guard = 0;
        bit  hs;
        while (i < n && guard < 2000) begin
            if (port) begin
                s1_tvalid = 1'b1;
                s1_tdata  = 8'(base + 8'(i) * step);
                s1_tlast  = (i == n - 1);
            end else begin
                s0_tvalid = 1'b1;
                s0_tdata  = 8'(base + 8'(i) * step);
                s0_tlast  = (i == n - 1);
            end
            @(negedge clk_1M024);
            hs = port ? (s1_tvalid && mx_s1_rdy) : (s0_tvalid && mx_s0_rdy);
            @(posedge clk_1M024);
            #1;
            guard++;
            if (hs) i++;
        end
        if (port) begin
            s1_tvalid = 1'b0;
            s1_tlast  = 1'b0;
        end else begin
            s0_tvalid = 1'b0;
            s0_tlast  = 1'b0;
        end
        if (i < n) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL send port%0d timeout: sent %0d, required %0d", port, i, n);
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((sb.size() != 0 || mx_busy || mx_tvalid) && n < 600) begin
            @(negedge clk_1M024);
            n++;
        end
        checkOutput({name, " drained"}, {31'd0, (sb.size() == 0 && !mx_busy && !mx_tvalid)}, 32'd1);
    endtask

    task automatic applyReset();
        @(negedge clk_1M024);
        rst_n_1M024 = 1'b0;
        repeat (2) @(negedge clk_1M024);
        rst_n_1M024 = 1'b1;
        @(posedge clk_1M024);
        #1;
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " tvalid"}, {31'd0, mx_tvalid}, 32'd0);
        checkOutput({name, " tlast"},  {31'd0, mx_tlast},  32'd0);
        checkOutput({name, " tuser"},  {31'd0, mx_tuser},  32'd0);
        checkOutput({name, " tdata"},  {24'd0, mx_tdata},  32'd0);
        checkOutput({name, " mode"},   {28'd0, mx_mode},   32'd1);
        checkOutput({name, " busy"},   {31'd0, mx_busy},   32'd0);
        checkOutput({name, " ovf"},    {24'd0, mx_ovf},    32'd0);
        checkOutput({name, " treadys"}, {30'd0, mx_s1_rdy, mx_s0_rdy}, 32'd0);
    endtask

    // Monitor: every accepted output beat is popped against the scoreboard.
    always @(negedge clk_1M024) begin
        if (mon_en && rst_n_1M024 && mx_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected beat: got data 0x%0h user %0b last %0b, expected none",
                         mx_tdata, mx_tuser, mx_tlast);
            end else begin
                checkOutput("beat {data,user,last,mode}",
                            {18'd0, mx_tdata, mx_tuser, mx_tlast, mx_mode}, {18'd0, sb.pop_front()});
            end
        end
    end

    // Tx ready: held high unless the random-backpressure phase is active.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk_1M024);
            #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int found;
        rst_n_1M024 = 1'b0;
        mode_cfg    = MODE_MIX;
        s0_tdata = 8'd0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata = 8'd0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        sel = 1'b0;
        rand_ready = 1'b0;
        repeat (3) @(posedge clk_1M024);
        #1;
        checkResetState("reset");
        @(negedge clk_1M024);
        rst_n_1M024 = 1'b1;
        @(posedge clk_1M024);
        #1;
        mon_en = 1'b1;

        // Single control frame, MIX mode, then measure the idle gap.
        $display("[TB] single s0 frame");
        expectFrame(8'hA1, MODE_BPSK, 8'h11, 8'h11, 3);
        applyStimulus(1'b0, 8'h11, 8'h11, 3);
        found = 0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge clk_1M024);
            found = int'(mx_tvalid && m_tready && mx_tlast);
            n++;
        end
        checkOutput("final beat seen", found, 1);
        n = 0;
        @(negedge clk_1M024);
        while (mx_busy && n < 100) begin
            n++;
            @(negedge clk_1M024);
        end
        checkOutput("gap cycles with busy", n, 16);
        waitIdle("single");

        // Simultaneous requests alternate, starting with port 0 after reset.
        $display("[TB] alternating arbitration");
        applyReset();
        expectFrame(8'hA1, MODE_BPSK, 8'hC1, 8'h01, 2);
        expectFrame(8'hA2, MODE_QPSK, 8'hD1, 8'h01, 2);
        fork
            applyStimulus(1'b0, 8'hC1, 8'h01, 2);
            applyStimulus(1'b1, 8'hD1, 8'h01, 2);
        join
        waitIdle("pair1");
        expectFrame(8'hA1, MODE_BPSK, 8'hE1, 8'h01, 2);
        expectFrame(8'hA2, MODE_QPSK, 8'hF1, 8'h01, 2);
        fork
            applyStimulus(1'b0, 8'hE1, 8'h01, 2);
            applyStimulus(1'b1, 8'hF1, 8'h01, 2);
        join
        waitIdle("pair2");

        // Random backpressure on a 10-byte frame; mode_cfg change mid-frame is ignored.
        $display("[TB] backpressure frame");
        rand_ready = 1'b1;
        expectFrame(8'hA1, MODE_BPSK, 8'h50, 8'h01, 10);
        fork
            applyStimulus(1'b0, 8'h50, 8'h01, 10);
            begin
                repeat (5) @(posedge clk_1M024);
                #1;
                mode_cfg = MODE_QPSK;
            end
        join
        waitIdle("backpressure");
        rand_ready = 1'b0;
        mode_cfg = MODE_MIX;

        // MAX_LEN=4 instance: exact-length frame, truncated frame, illegal mode.
        $display("[TB] MAX_LEN=4 instance");
        sel = 1'b1;
        mode_cfg = MODE_QPSK;
        expectFrame(8'hA2, MODE_QPSK, 8'h41, 8'h01, 4);
        applyStimulus(1'b0, 8'h41, 8'h01, 4);
        waitIdle("exact len");
        checkOutput("ovf after exact len", {24'd0, mx_ovf}, 32'd0);
        mode_cfg = MODE_MIX;
        expectFrame(8'hA2, MODE_QPSK, 8'h01, 8'h01, 4);
        applyStimulus(1'b1, 8'h01, 8'h01, 6);
        waitIdle("truncated");
        checkOutput("ovf after truncation", {24'd0, mx_ovf}, 32'd1);
        mode_cfg = 4'b1000;
        expectFrame(8'hA1, MODE_BPSK, 8'h91, 8'h01, 2);
        applyStimulus(1'b1, 8'h91, 8'h01, 2);
        waitIdle("illegal mode");
        mode_cfg = MODE_MIX;

        // Reset while byte 3 of a control frame is being presented.
        $display("[TB] reset mid-frame");
        sel = 1'b0;
        mon_en = 1'b0;
        n = 0;
        found = 0;
        while (found < 2 && n < 100) begin
            s0_tvalid = 1'b1;
            s0_tdata  = 8'(8'h71 + 8'(found));
            s0_tlast  = 1'b0;
            @(negedge clk_1M024);
            if (mx_s0_rdy) found++;
            @(posedge clk_1M024);
            #1;
            n++;
        end
        s0_tdata = 8'h73;
        @(negedge clk_1M024);
        rst_n_1M024 = 1'b0;
        #1;
        checkResetState("mid-frame reset");
        checkOutput("dut_b ovf after reset", {24'd0, b_ovf}, 32'd0);
        s0_tvalid = 1'b0;
        repeat (2) @(negedge clk_1M024);
        rst_n_1M024 = 1'b1;
        @(posedge clk_1M024);
        #1;
        sb.delete();
        mon_en = 1'b1;
        expectFrame(8'hA1, MODE_BPSK, 8'h81, 8'h01, 3);
        applyStimulus(1'b0, 8'h81, 8'h01, 3);
        waitIdle("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
